// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe -- registered WIDTH-bit bitwise logic unit for the TRISC datapath.
//
// Eight bitwise ops over operands a and b (or the accumulator in place of b),
// one-deep output register with valid/ready handshake, registered zero/neg flags.
//
// Optional feature macro: LU_ACC_EN
//   defined   : accumulator register present; use_acc selects acc as the B operand;
//               acc takes every accepted result.
//   undefined : no accumulator; use_acc is ignored; B is always b.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   in_valid  operand set presented
//   in_ready  unit can accept operands this cycle (!out_valid || out_ready)
//   a, b      operands (WIDTH bits)
//   op        operation select: 000 AND, 001 XOR, 010 OR, 011 NOR,
//             100 NAND, 101 XNOR, 110 PASS A, 111 NOT A
//   use_acc   replace b with the accumulator (LU_ACC_EN builds only)
//   out_valid result register holds an unconsumed result
//   out_ready downstream consumes the result this cycle
//   result    registered result
//   zero      result == 0
//   neg       result[WIDTH-1]

// Single-bit logic cell; one instance per result bit.
module lu_bit_cell (
   input  logic [2:0] op,
   input  logic       a,
   input  logic       b,
   output logic       y
);
   always_comb begin
      y = 1'b0;
      case (op)
         3'b000: y = a & b;
         3'b001: y = a ^ b;
         3'b010: y = a | b;
         3'b011: y = ~(a | b);
         3'b100: y = ~(a & b);
         3'b101: y = ~(a ^ b);
         3'b110: y = a;
         3'b111: y = ~a;
         default: y = 1'b0;
      endcase
   end
endmodule

module logic_unit_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             use_acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             neg
);
   logic [WIDTH-1:0] eff_b;
   logic [WIDTH-1:0] nxt;
   logic             accept;

   // Ready whenever the output slot is empty or is being drained this cycle.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

`ifdef LU_ACC_EN
   logic [WIDTH-1:0] acc;

   assign eff_b = use_acc ? acc : b;

   // acc follows every accepted result, whatever use_acc was.
   always_ff @(posedge clk) begin
      if (rst)
         acc <= '0;
      else if (accept)
         acc <= nxt;
   end
`else
   logic unused_use_acc;

   assign unused_use_acc = use_acc;
   assign eff_b          = b;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      lu_bit_cell u_cell (
         .op (op),
         .a  (a[i]),
         .b  (eff_b[i]),
         .y  (nxt[i])
      );
   end

   // Output register. Flags are registered alongside the result so they can
   // never disagree with it; a held result (out_ready=0) keeps all three stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         result    <= '0;
         zero      <= 1'b1;
         neg       <= 1'b0;
         out_valid <= 1'b0;
      end else if (accept) begin
         result    <= nxt;
         zero      <= (nxt == '0);
         neg       <= nxt[WIDTH-1];
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;
   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             use_acc;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             neg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .use_acc   (use_acc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .neg       (neg)
   );

   // Reference: the op table written directly as word-level expressions.
   function automatic logic [WIDTH-1:0] ref_f(input logic [2:0] o,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
      case (o)
         3'd0: return x & y;
         3'd1: return x ^ y;
         3'd2: return x | y;
         3'd3: return ~(x | y);
         3'd4: return ~(x & y);
         3'd5: return ~(x ^ y);
         3'd6: return x;
         default: return ~x;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] o, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input logic ua, input logic ordy);
      in_valid  = v;
      op        = o;
      a         = x;
      b         = y;
      use_acc   = ua;
      out_ready = ordy;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b1, 3'd2, 8'hFF, 8'hFF, 1'b0, 1'b0);
      step();
      step();
      checks++;
      if (out_valid !== 1'b0 || result !== 8'h00 || zero !== 1'b1 || neg !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: out_valid=%b result=%h zero=%b neg=%b, want 0 00 1 0",
                  out_valid, result, zero, neg);
      end
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_all_ops();
      logic [WIDTH-1:0] exp_r [8] = '{8'h81, 8'h66, 8'hE7, 8'h18, 8'h7E, 8'h99, 8'hC3, 8'h3C};
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 3'(i), 8'hC3, 8'hA5, 1'b0, 1'b1);
         step();
         checks++;
         if (out_valid !== 1'b1 || result !== exp_r[i] || neg !== exp_r[i][7] ||
             zero !== 1'b0) begin
            errors++;
            $display("FAIL all_ops op=%0d: valid=%b result=%h neg=%b zero=%b, want 1 %h %b 0",
                     i, out_valid, result, neg, zero, exp_r[i], exp_r[i][7]);
         end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      drive(1'b1, 3'd0, 8'hFF, 8'h0F, 1'b0, 1'b0);
      step();
      // Different operands offered while stalled must not be taken.
      drive(1'b1, 3'd7, 8'h00, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 8'h0F || zero !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_hold cyc%0d: in_ready=%b valid=%b result=%h, want 0 1 0f",
                     i, in_ready, out_valid, result);
         end
         step();
      end
      drive(1'b1, 3'd1, 8'hFF, 8'hFF, 1'b0, 1'b1);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_release_ready: got %b want 1", in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || result !== 8'h00 || zero !== 1'b1 || neg !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_b2b: valid=%b result=%h zero=%b neg=%b, want 1 00 1 0",
                  out_valid, result, zero, neg);
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_drain: out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_acc();
      logic [WIDTH-1:0] exp2;
`ifdef LU_ACC_EN
      exp2 = 8'h55;
`else
      exp2 = 8'h0F ^ 8'h33;
`endif
      drive(1'b1, 3'd1, 8'h5A, 8'h00, 1'b0, 1'b1);
      step();
      checks++;
      if (result !== 8'h5A) begin
         errors++;
         $display("FAIL acc_first: result=%h want 5a", result);
      end
      drive(1'b1, 3'd1, 8'h0F, 8'h33, 1'b1, 1'b1);
      step();
      checks++;
      if (result !== exp2 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL acc_second: result=%h valid=%b want %h 1", result, out_valid, exp2);
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      logic [WIDTH-1:0] exp_r;
`ifdef LU_ACC_EN
      exp_r = 8'h00;
`else
      exp_r = 8'h6C;
`endif
      drive(1'b1, 3'd2, 8'h12, 8'h34, 1'b0, 1'b0);
      step();
      checks++;
      if (out_valid !== 1'b1 || result !== 8'h36) begin
         errors++;
         $display("FAIL reset_mid_pending: valid=%b result=%h want 1 36", out_valid, result);
      end
      rst = 1'b1;
      in_valid = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0 || result !== 8'h00 || zero !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_clear: valid=%b result=%h zero=%b want 0 00 1",
                  out_valid, result, zero);
      end
      rst = 1'b0;
      drive(1'b1, 3'd0, 8'hFF, 8'h6C, 1'b1, 1'b1);
      step();
      checks++;
      if (result !== exp_r || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_acc: result=%h valid=%b want %h 1", result, out_valid, exp_r);
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] q[$];
      logic [WIDTH-1:0] macc;
      logic [WIDTH-1:0] r;
      int accepted = 0;
      int consumed = 0;
      bit exp_ready;
      rst = 1'b1;
      in_valid = 1'b0;
      step();
      rst = 1'b0;
      macc = '0;
      for (int n = 0; n < 1100; n++) begin
         if (n < 1000)
            drive(1'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom_range(0, 3) != 0));
         else
            drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1);
         #1;
         exp_ready = (q.size() == 0) || out_ready;
         checks++;
         if (in_ready !== exp_ready || out_valid !== (q.size() != 0)) begin
            errors++;
            $display("FAIL random_hs n=%0d: in_ready=%b valid=%b want %b %b",
                     n, in_ready, out_valid, exp_ready, q.size() != 0);
         end
         if (q.size() != 0) begin
            checks++;
            if (result !== q[0] || zero !== (q[0] == 0) || neg !== q[0][WIDTH-1]) begin
               errors++;
               $display("FAIL random_data n=%0d: result=%h zero=%b neg=%b want %h",
                        n, result, zero, neg, q[0]);
            end
            if (out_ready) begin
               void'(q.pop_front());
               consumed++;
            end
         end
         if (in_valid && exp_ready) begin
`ifdef LU_ACC_EN
            r = ref_f(op, a, use_acc ? macc : b);
`else
            r = ref_f(op, a, b);
`endif
            macc = r;
            q.push_back(r);
            accepted++;
         end
         step();
      end
      checks++;
      if (accepted != consumed || q.size() != 0 || accepted < 100) begin
         errors++;
         $display("FAIL random_count: accepted=%0d consumed=%0d left=%0d",
                  accepted, consumed, q.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
      test_reset();
      test_all_ops();
      test_backpressure();
      test_acc();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
